// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Shares one 0..15-position shift step between two requesters and
//            sequences shifts of 0..2^AMT_W-1 positions, one chunk of at most
//            15 positions per clock. Returns result, {S,Z,C,V} flags and the
//            requester ID through a valid/ready response port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid / reqN_ready  request handshake for requester N (0 or 1)
//   reqN_a / reqN_op         16-bit operand, opcode (8 SLL, 9 SLR, 10 SRL, 11 SRA)
//   reqN_amt                 total shift amount
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester index of the response
//   rsp_out / rsp_cond       result and {S,Z,C,V} flags
//   rsp_err                  opcode was outside 8..11
//   busy                     an operation is running or awaiting acceptance
// ============================================================================
module shift_sequencer #(
  parameter int AMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [15:0]      req0_a,
  input  logic [3:0]       req0_op,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [15:0]      req1_a,
  input  logic [3:0]       req1_op,
  input  logic [AMT_W-1:0] req1_amt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_out,
  output logic [3:0]       rsp_cond,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;       // round-robin pointer: preferred port on a tie
  logic             id_q, id_d;
  logic [3:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;     // positions still to shift
  logic [15:0]      work_q, work_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;

  // --------------------------------------------------------------------------
  // Grant: a lone valid port wins; on a tie the round-robin pointer decides.
  // --------------------------------------------------------------------------
  logic grant_any;
  logic grant_id;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? rr_q : req1_valid;
  end

  assign req0_ready = (state_q == S_IDLE) && grant_any && !grant_id;
  assign req1_ready = (state_q == S_IDLE) && grant_any &&  grant_id;

  // --------------------------------------------------------------------------
  // One chunk of shifting. Each shift is done one bit wider than the operand
  // so the extra bit captures the last bit shifted out; a chunk of 0 leaves
  // that bit at 0, which yields carry = 0 without a special case.
  // --------------------------------------------------------------------------
  logic [3:0]        chunk;
  logic [AMT_W-1:0]  rem_next;
  logic [16:0]       sll_ext;
  logic [16:0]       srl_ext;
  logic signed [16:0] sra_ext;
  logic [15:0]       rol_res;
  logic [15:0]       shift_res;
  logic              shift_c;

  always_comb begin
    chunk    = (rem_q > AMT_W'(15)) ? 4'd15 : rem_q[3:0];
    rem_next = rem_q - AMT_W'(chunk);
    sll_ext  = {1'b0, work_q} << chunk;
    srl_ext  = {work_q, 1'b0} >> chunk;
    sra_ext  = $signed({work_q, 1'b0}) >>> chunk;
    // Right shift by 16 (chunk 0) is all zeros, so rotate-by-0 is identity.
    rol_res  = (work_q << chunk) | (work_q >> (5'd16 - {1'b0, chunk}));

    shift_res = work_q;
    shift_c   = 1'b0;
    case (op_q)
      4'd8: begin
        shift_res = sll_ext[15:0];
        shift_c   = sll_ext[16];
      end
      4'd9: begin
        shift_res = rol_res;
        shift_c   = 1'b0;
      end
      4'd10: begin
        shift_res = srl_ext[16:1];
        shift_c   = srl_ext[0];
      end
      4'd11: begin
        shift_res = sra_ext[16:1];
        shift_c   = sra_ext[0];
      end
      default: begin
        // Illegal opcode: operand passes through, chunk count still consumed.
        shift_res = work_q;
        shift_c   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    op_d    = op_q;
    rem_d   = rem_q;
    work_d  = work_q;
    carry_d = carry_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          state_d = S_RUN;
          id_d    = grant_id;
          rr_d    = ~grant_id;
          work_d  = grant_id ? req1_a   : req0_a;
          op_d    = grant_id ? req1_op  : req0_op;
          rem_d   = grant_id ? req1_amt : req0_amt;
          carry_d = 1'b0;
          err_d   = grant_id ? (req1_op[3:2] != 2'b10) : (req0_op[3:2] != 2'b10);
        end
      end
      S_RUN: begin
        // amt = 0 passes through here once with chunk 0.
        work_d  = shift_res;
        carry_d = shift_c;
        rem_d   = rem_next;
        if (rem_next == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= 4'd0;
      rem_q   <= '0;
      work_q  <= 16'd0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Response outputs come straight from registers and read as zero outside
  // DONE.
  // --------------------------------------------------------------------------
  always_comb begin
    rsp_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    rsp_id    = rsp_valid & id_q;
    rsp_err   = rsp_valid & err_q;
    rsp_out   = rsp_valid ? work_q : 16'd0;
    rsp_cond  = rsp_valid ? {work_q[15], (work_q == 16'd0), carry_q, 1'b0} : 4'd0;
  end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle controller that shares one 0..15-position shift step between two requesters (execute stage and microcode/multiply unit) and sequences shifts of 0..63 positions. Each amount is split into chunks of at most 15 positions, one chunk per cycle. Opcode encoding and condition-code layout match the `shifter` unit. The block returns the final result, flags and requester ID through a valid/ready response port.

## Interface
- AMT_W, 6: shift-amount width; legal amounts 0..2^AMT_W-1.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid / req1_valid  in  1  requester n has an operation.
- req0_ready / req1_ready  out  1  requester n accepted when valid&ready at a clk edge.
- req0_a / req1_a  in  16  operand.
- req0_op / req1_op  in  4  opcode: 8 SLL, 9 SLR (rotate left), 10 SRL, 11 SRA.
- req0_amt / req1_amt  in  AMT_W  total shift amount.
- rsp_valid  out  1  response available; held until accepted.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester index of this response.
- rsp_out  out  16  result.
- rsp_cond  out  4  {S,Z,C,V}: [3]=rsp_out[15], [2]=(rsp_out==0), [1]=carry, [0]=0.
- rsp_err  out  1  opcode was not 8..11.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE. In IDLE, rsp_valid, rsp_id, rsp_out, rsp_cond, rsp_err, busy and both readies are 0, with one exception: the granted requester's ready (see Grant). RR pointer resets to 0.
- Grant (IDLE only, combinational):
  - Exactly one valid: that port is granted.
  - Both valid: the port equal to the RR pointer is granted.
  - Only the granted port sees ready=1.
  - On acceptance: latch a, op, amt and id; set RR pointer = 1 − granted id; go to RUN.
- RUN, one edge per chunk:
  - Chunk = min(remaining, 15).
  - The working register is shifted by the chunk; remaining decrements by the chunk.
  - Carry register takes that chunk's carry.
  - When remaining reaches 0, go to DONE.
  - amt=0 takes one RUN edge with chunk 0 and leaves the result unchanged.
- Chunk semantics, n = chunk:
  - SLL: zero fill; carry = last bit shifted out of bit 15.
  - SLR: rotate left; carry = 0.
  - SRL: zero fill; carry = last bit shifted out of bit 0.
  - SRA: sign fill; carry = last bit shifted out of bit 0.
  - n=0: carry = 0.
- Final carry = carry of the last chunk. This equals the last bit shifted out over the whole operation, e.g. SLL ≥17 gives 0 and SRA ≥16 gives the sign bit.
- Illegal opcode: result = operand unchanged, carry = 0, rsp_err = 1. The same chunk count is consumed.
- DONE: rsp_* driven from registers and stable while rsp_valid=1 and rsp_ready=0. When rsp_valid&rsp_ready at an edge, go to IDLE. A new request is not accepted in that same cycle.
- Requests arriving while busy wait; requesters must hold valid and operands stable until ready.

## Timing
- k = max(1, ceil(amt/15)).
- Acceptance at edge E; rsp_valid rises at edge E+k.
- Minimum issue interval per operation is k+2 cycles (IDLE accept, k RUN edges, DONE handshake).
- rst asserted at any edge forces IDLE at that edge:
  - rsp_valid = 0 from that edge.
  - Any in-flight operation is discarded with no response.
  - RR pointer = 0.
- rsp_ready has no effect outside DONE.
- amt = 2^AMT_W − 1 (63) gives k=5 (15,15,15,15,3).

## Test plan
- req0 a=0x8001 op=8 amt=1 → rsp_out=0x0002, rsp_cond=4'b0010, rsp_id=0, rsp_valid one cycle after acceptance.
- req1 a=0x8001 op=9 amt=20 → chunks 15,5; rsp_out=0x0018, rsp_cond=4'b0000, rsp_id=1, rsp_valid at E+2.
- req0 a=0x8000 op=11 amt=40 → chunks 15,15,10; rsp_out=0xFFFF, rsp_cond=4'b1010, rsp_valid at E+3. Same operands with op=10 → rsp_out=0x0000, rsp_cond=4'b0100.
- req0 and req1 both valid from reset and held → port 0 served first, then port 1, then port 0 again.
  - Each response carries the correct rsp_id.
  - Non-granted ready stays 0.
- Response backpressure:
  - rsp_ready held 0 for 5 cycles in DONE → rsp_* stable, busy=1, no readies asserted.
  - Response accepted on the cycle rsp_ready rises; next request accepted no earlier than the following cycle.
- Corner cases:
  - a=0x1234 op=10 amt=0 → 0x1234, rsp_cond=4'b0000, k=1.
  - op=3 → rsp_err=1, rsp_out equals operand.
  - rst pulsed mid-RUN of an amt=63 operation → rsp_valid never asserts; IDLE with pointer 0 on the next edge.
